instr_encoder: RTL

//  Inverse of the decode stage: packs instruction fields (opcode, rs, rt, rd, func, imm) into
//  16-bit WISC words and writes them sequentially into instruction memory via a write port.

---
 rtl/instr_encoder_pkg.sv | 50 +++++
 rtl/instr_encoder_fmt_pack.sv | 56 +++++
 rtl/instr_encoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, instruction format classes and FSM state type for the
// WISC instruction encoder.
package instr_encoder_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_SIIC = 5'b00010;
  localparam logic [4:0] OP_SLBI = 5'b10010;
  localparam logic [4:0] OP_BTR  = 5'b11001;

  typedef enum logic [2:0] {
    FMT_N  = 3'd0,
    FMT_J  = 3'd1,
    FMT_I1 = 3'd2,
    FMT_I2 = 3'd3,
    FMT_R  = 3'd4
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic fmt_e op_format(input logic [4:0] op);
    fmt_e f;
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011: f = FMT_N;
      5'b00100, 5'b00110:                     f = FMT_J;
      5'b00101, 5'b00111, 5'b01100, 5'b01101,
      5'b01110, 5'b01111, 5'b10010, 5'b11000: f = FMT_I2;
      5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10000, 5'b10001, 5'b10011, 5'b10100,
      5'b10101, 5'b10110, 5'b10111:           f = FMT_I1;
      default:                                f = FMT_R;
    endcase
    return f;
  endfunction

  // Opcodes whose immediate is a zero-extended field rather than two's complement.
  function automatic logic imm_is_unsigned(input logic [4:0] op);
    logic u;
    case (op)
      5'b01010, 5'b01011, 5'b10010,
      5'b10100, 5'b10101, 5'b10110, 5'b10111: u = 1'b1;
      default:                                u = 1'b0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/instr_encoder_fmt_pack.sv
// Combinational packer: opcode plus instruction fields into one 16-bit WISC word,
// flagging immediates that do not fit the field width of their format.
module instr_encoder_fmt_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  opcode_i,
  input  logic [2:0]  rs_i,
  input  logic [2:0]  rt_i,
  input  logic [2:0]  rd_i,
  input  logic [1:0]  func_i,
  input  logic [10:0] imm_i,
  output logic [15:0] word_o,
  output logic        imm_oor_o
);

  // Field placement and range check per format; unused fields never reach the word.
  always_comb begin
    word_o        = 16'h0000;
    imm_oor_o     = 1'b0;
    word_o[15:11] = opcode_i;
    case (op_format(opcode_i))
      FMT_N: begin
        if (opcode_i == OP_SIIC) word_o[10:8] = rs_i;
        else                     word_o[10:8] = 3'b000;
      end
      FMT_J: begin
        word_o[10:0] = imm_i;
      end
      FMT_I2: begin
        word_o[10:8] = rs_i;
        word_o[7:0]  = imm_i[7:0];
        if (imm_is_unsigned(opcode_i)) imm_oor_o = (imm_i[10:8] != 3'b000);
        else imm_oor_o = (imm_i[10:7] != 4'b0000) && (imm_i[10:7] != 4'b1111);
      end
      FMT_I1: begin
        word_o[10:8] = rs_i;
        word_o[7:5]  = rd_i;
        word_o[4:0]  = imm_i[4:0];
        if (imm_is_unsigned(opcode_i)) imm_oor_o = (imm_i[10:5] != 6'b000000);
        else imm_oor_o = (imm_i[10:4] != 7'h00) && (imm_i[10:4] != 7'h7F);
      end
      FMT_R: begin
        word_o[10:8] = rs_i;
        if (opcode_i == OP_BTR) word_o[7:5] = 3'b000;
        else                    word_o[7:5] = rt_i;
        word_o[4:2] = rd_i;
        if ((opcode_i == OP_BTR) || (opcode_i[4:2] == 3'b111)) word_o[1:0] = 2'b00;
        else                                                    word_o[1:0] = func_i;
      end
      default: begin
        word_o = 16'h0000;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction image builder: accepts field bundles, encodes them and writes the words
// to sequential memory addresses, stopping on HALT or when the address space is used up.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [1:0]        in_func,
  input  logic [10:0]       in_imm,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_stall,
  output logic [ADDR_W-1:0] words,
  output logic              range_err,
  output logic              done,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] words_q, words_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              full_q, full_d;
  logic [15:0]       pack_word_s;
  logic              pack_oor_s;
  logic              accept_s;
  logic              commit_s;
  logic              halt_s;

  instr_encoder_fmt_pack u_pack (
    .opcode_i  (in_opcode),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .func_i    (in_func),
    .imm_i     (in_imm),
    .word_o    (pack_word_s),
    .imm_oor_o (pack_oor_s)
  );

  assign accept_s = in_valid && in_ready;
  assign commit_s = (state_q == ST_WRITE) && !mem_stall;
  assign halt_s   = (wdata_q[15:11] == OP_HALT);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (accept_s) state_d = ST_WRITE;
        ST_WRITE: if (!mem_stall) state_d = halt_s ? ST_DONE : ST_IDLE;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !full_q;
  end

  // Write-port, counter and sticky-flag next values.
  always_comb begin
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    err_d   = err_q;
    done_d  = done_q;
    full_d  = full_q;
    if (clear) begin
      wr_en_d = 1'b0;
      addr_d  = BASE_ADDR;
      words_d = '0;
      err_d   = 1'b0;
      done_d  = 1'b0;
      full_d  = 1'b0;
    end else if (accept_s) begin
      wr_en_d = 1'b1;
      wdata_d = pack_word_s;
      err_d   = err_q | pack_oor_s;
    end else if (commit_s) begin
      wr_en_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(2);
      words_d = words_q + ADDR_W'(1);
      if (addr_q == LAST_ADDR) full_d = 1'b1;
      else                     full_d = full_q;
      if (halt_s) done_d = 1'b1;
      else        done_d = done_q;
    end else begin
      wr_en_d = wr_en_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 16'h0000;
      words_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      err_q   <= err_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  assign mem_wr_en = wr_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign words     = words_q;
  assign range_err = err_q;
  assign done      = done_q;
  assign full      = full_q;

endmodule
